// File: rtl/wb_cmd_master.sv
// wb_cmd_master: decodes read/write commands from a received byte stream and
// issues single 32-bit Wishbone cycles, then returns a status byte or the read
// data on the byte transmit interface.
//
// Build option: define WB_CMD_TIMEOUT_EN to add a watchdog that aborts a bus
// cycle after timeout_cycles cycles without ack/err. Without it, BUS waits
// indefinitely.
//
// Command bytes (multi-byte fields MSB first):
//   0x01 A3 A2 A1 A0 D3 D2 D1 D0   write
//   0x02 A3 A2 A1 A0               read
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an opcode byte; unknown opcodes are ignored
// ADDR  | shifting in four address bytes
// DATA  | shifting in four write-data bytes (write commands only)
// BUS   | Wishbone cycle in flight; waits for ack/err (or watchdog)
// RESP  | streaming the loaded response bytes out on tx
module wb_cmd_master #(
  parameter int unsigned timeout_cycles = 1024,
  parameter logic [7:0]  ack_byte       = 8'hA5,
  parameter logic [7:0]  err_byte       = 8'hEE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_we_q, cmd_we_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] resp_q, resp_d;
  logic [2:0]  resp_cnt_q, resp_cnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        timeout_hit;

  // A watchdog of fewer than two cycles cannot be honoured.
  if (timeout_cycles < 2) begin : g_bad_timeout
    $error("wb_cmd_master: timeout_cycles must be >= 2");
  end

`ifdef WB_CMD_TIMEOUT_EN
  logic [31:0] tmr_q, tmr_d;

  // Watchdog counts BUS cycles; it sits at zero outside BUS so entry clears it.
  always_comb begin
    tmr_d = '0;
    if (state_q == S_BUS) begin
      tmr_d = tmr_q + 32'd1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign timeout_hit = (state_q == S_BUS) && (tmr_q == 32'(timeout_cycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Command decode, bus handshake and response sequencing.
  always_comb begin
    state_d    = state_q;
    cmd_we_d   = cmd_we_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    tx_wr_d    = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
          cmd_we_d = (rx_data == OP_WRITE);
          cnt_d    = 2'd0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          adr_d = {adr_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (cmd_we_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              cyc_d   = 1'b1;
              we_d    = 1'b0;
            end
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          dat_d = {dat_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
          end
        end
      end

      S_BUS: begin
        // err outranks ack; either outranks the watchdog.
        if (wb_err_i) begin
          resp_d     = {err_byte, 24'h0};
          resp_cnt_d = 3'd1;
        end else if (wb_ack_i) begin
          if (cmd_we_q) begin
            resp_d     = {ack_byte, 24'h0};
            resp_cnt_d = 3'd1;
          end else begin
            resp_d     = wb_dat_i;
            resp_cnt_d = 3'd4;
          end
        end else if (timeout_hit) begin
          resp_d     = {err_byte, 24'h0};
          resp_cnt_d = 3'd1;
        end
        if (wb_err_i || wb_ack_i || timeout_hit) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        // The cycle carrying the last strobe is the exit cycle, so rx bytes
        // arriving then are still dropped.
        if (resp_cnt_q == 3'd0) begin
          state_d = S_IDLE;
        end else if (!tx_busy && !tx_wr_q) begin
          // tx_wr_q guards against tx_busy not yet reflecting the last strobe.
          tx_wr_d    = 1'b1;
          tx_data_d  = resp_q[31:24];
          resp_d     = {resp_q[23:0], 8'h00};
          resp_cnt_d = resp_cnt_q - 3'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial command or cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_we_q   <= 1'b0;
      cnt_q      <= 2'd0;
      adr_q      <= '0;
      dat_q      <= '0;
      resp_q     <= '0;
      resp_cnt_q <= 3'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_we_q   <= cmd_we_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign wb_adr_o = {adr_q[31:2], 2'b00};
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Byte-stream-driven Wishbone bus master: the initiator counterpart to the system's Wishbone slaves (bram, sram, uart, timer).
- Decodes read/write commands arriving on a byte interface (from a uart core's rx side) and issues single 32-bit Wishbone cycles on a spare interconnect master port (m2).
- Returns read data / status bytes on a byte tx interface.
- Used for host-side debug load/peek/poke without CPU involvement.

Parameters:
- timeout_cycles, 1024: bus cycles without ack/err before abort (used only with WB_CMD_TIMEOUT_EN); must be ≥2.
- ack_byte, 8'hA5: status byte returned after a successful write.
- err_byte, 8'hEE: status byte returned on bus error or timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_busy  in  1  transmitter busy
- wb_adr_o  out  32  Wishbone address, bits [1:0] always 0
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte select, always 4'hF
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0 except wb_sel_o=4'hF.
  - State IDLE; byte counters cleared; address/data registers cleared.
  - Reset mid-cycle drops cyc/stb immediately and discards the partial command.
- Command format (multi-byte fields MSB first):
  - 0x01 = write: opcode, A3..A0, D3..D0.
  - 0x02 = read: opcode, A3..A0.
  - Any other opcode in IDLE is ignored; state stays IDLE and nothing is transmitted.
- States:
  - IDLE: on rx_valid with opcode 0x01/0x02, latch we and go to ADDR with cnt=0.
  - ADDR: each rx_valid shifts a byte into adr (adr <= {adr[23:0],rx_data}). After the 4th byte, go to DATA if write, BUS if read.
  - DATA: same shifting into dat. After the 4th byte, go to BUS.
  - BUS:
    - On entry (first BUS cycle), assert cyc=stb=1, we per command, adr={adr[31:2],2'b00}.
    - Hold until wb_ack_i or wb_err_i is sampled high.
    - The edge sampling ack/err deasserts cyc/stb/we the next cycle. No back-to-back cycles; one bus cycle per command.
    - On ack: read latches wb_dat_i and loads 4 response bytes; write loads 1 byte (ack_byte).
    - On err: loads 1 byte (err_byte); read data discarded.
    - ack and err sampled in the same cycle: err wins.
  - RESP:
    - Sends loaded bytes in order (read data MSB first).
    - tx_wr pulses for exactly one cycle with tx_data valid, only when tx_busy=0 and no pulse was issued in the previous cycle (one-cycle guard for tx_busy rise latency).
    - After the last byte is strobed, return to IDLE.
- rx_valid while in BUS or RESP: byte dropped, no state effect.
- rx_valid in IDLE on the same cycle RESP exits: not possible (the exit cycle is still RESP); the byte is dropped.
- Minimum latency: the 4th address byte (read) or 4th data byte (write) strobe → cyc/stb high the next cycle. Zero-wait ack → first tx_wr 2 cycles after ack (if tx_busy=0).
- No inter-byte timeout; a lost byte desynchronises the stream until enough bytes complete the command (host resyncs with reset or padding).

Optional Feature:
- Macro WB_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments each BUS cycle.
  - If it reaches timeout_cycles-1 with no ack/err, the cycle aborts: cyc/stb drop the next cycle and err_byte is sent.
  - ack/err arriving on the same cycle as the timeout has priority over the timeout.
- Undefined: no counter is synthesised and BUS waits indefinitely.

Test Plan:
- Write: bytes 01 00 00 10 04 DE AD BE EF, zero-wait ack → one cycle with adr=0x00001004, dat=0xDEADBEEF, we=1, sel=F; tx emits A5.
- Read: bytes 02 40 00 00 08, ack after 3 wait cycles with wb_dat_i=0x12345678 → tx emits 12 34 56 78 in order; tx_wr never pulses while tx_busy=1 (bench holds busy 10 cycles after each strobe).
- Unaligned/error: bytes 02 00 00 00 03 with err=1 → adr_o=0x00000000; tx emits EE only.
- Junk/drop: byte 7F in IDLE → no tx, busy stays 0. Bytes sent during BUS are dropped, and the next valid command executes correctly.
- Reset mid-cycle: reset_n low while cyc=1 → cyc/stb/tx_wr 0 asynchronously; after release, a full read command completes normally.
- Timeout (WB_CMD_TIMEOUT_EN, timeout_cycles=16): read with no ack → cyc high exactly 16 cycles, then EE. Same bench without macro → cyc stays high for 1000 cycles.
